// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch between the PC register and IF/ID.
// Ports: clk_i/rst_i (async low); start_i, pc_i, stall_i, flush_i in;
//   pc_write_o to the PC register; imem_req_o/imem_addr_o/imem_ack_i/
//   imem_data_i memory handshake; ifid_valid_o/pc_o/pc4_o/inst_o out.
//   Optional FETCH_PERF_EN macro adds perf_fetch_cnt_o, perf_wait_cnt_o.
module fetch_stage #(
   parameter logic [31:0] NOP_INST = 32'h0000_0000,
   parameter logic [31:0] PC_INC   = 32'd4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] pc_i,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic        pc_write_o,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic        ifid_valid_o,
   output logic [31:0] ifid_pc_o,
   output logic [31:0] ifid_pc4_o,
   output logic [31:0] ifid_inst_o
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt_o,
   output logic [31:0] perf_wait_cnt_o
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD,
      DRAIN
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [31:0] addr_q;
   logic [31:0] skid_pc;
   logic [31:0] skid_inst;
   logic        accept;
   logic        skid_move;
   logic        squash;
   logic        bubble;
   logic        park;

   always_comb begin
      state_nx    = state;
      pc_write_o  = 1'b0;
      imem_req_o  = 1'b0;
      imem_addr_o = 32'h0;
      accept      = 1'b0;
      skid_move   = 1'b0;
      squash      = 1'b0;
      bubble      = 1'b0;
      park        = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) state_nx = FETCH;
         end
         FETCH: begin
            imem_req_o  = 1'b1;
            imem_addr_o = pc_i;
            if (flush_i) begin
               pc_write_o = 1'b1;
               squash     = 1'b1;
               // request still outstanding: wait out its ack
               if (!imem_ack_i) state_nx = DRAIN;
            end else if (imem_ack_i && stall_i) begin
               park     = 1'b1;
               state_nx = HOLD;
            end else if (imem_ack_i) begin
               accept     = 1'b1;
               pc_write_o = 1'b1;
            end else if (!stall_i) begin
               bubble = 1'b1;
            end
         end
         HOLD: begin
            if (flush_i) begin
               pc_write_o = 1'b1;
               squash     = 1'b1;
               state_nx   = FETCH;
            end else if (!stall_i) begin
               skid_move  = 1'b1;
               pc_write_o = 1'b1;
               state_nx   = FETCH;
            end
         end
         DRAIN: begin
            // old address held while the PC already moved
            imem_req_o  = 1'b1;
            imem_addr_o = addr_q;
            if (flush_i) begin
               pc_write_o = 1'b1;
               squash     = 1'b1;
            end
            // the stale response closes the old transaction
            if (imem_ack_i) state_nx = FETCH;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= IDLE;
         addr_q    <= 32'h0;
         skid_pc   <= 32'h0;
         skid_inst <= 32'h0;
      end else begin
         state <= state_nx;
         if (state == FETCH) addr_q <= imem_addr_o;
         if (park) begin
            skid_pc   <= imem_addr_o;
            skid_inst <= imem_data_i;
         end else if (squash) begin
            skid_pc   <= 32'h0;
            skid_inst <= 32'h0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ifid_valid_o <= 1'b0;
         ifid_pc_o    <= 32'h0;
         ifid_pc4_o   <= 32'h0;
         ifid_inst_o  <= NOP_INST;
      end else begin
         unique case (1'b1)
            accept: begin
               ifid_valid_o <= 1'b1;
               ifid_pc_o    <= imem_addr_o;
               ifid_pc4_o   <= imem_addr_o + PC_INC;
               ifid_inst_o  <= imem_data_i;
            end
            skid_move: begin
               ifid_valid_o <= 1'b1;
               ifid_pc_o    <= skid_pc;
               ifid_pc4_o   <= skid_pc + PC_INC;
               ifid_inst_o  <= skid_inst;
            end
            squash, bubble: begin
               ifid_valid_o <= 1'b0;
               ifid_inst_o  <= NOP_INST;
            end
            default: ;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         perf_fetch_cnt_o <= 32'h0;
         perf_wait_cnt_o  <= 32'h0;
      end else begin
         if (accept || skid_move)
            perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
         if (imem_req_o && !imem_ack_i)
            perf_wait_cnt_o <= perf_wait_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table plus scoreboard for fetch_stage.
// Ends with a reset-in-HOLD sequence and a one-line summary.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] pc = 32'h0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        pc_write;
   logic        req;
   logic [31:0] addr;
   logic        ack = 1'b0;
   logic [31:0] data = 32'h0;
   logic        v;
   logic [31:0] ipc;
   logic [31:0] ipc4;
   logic [31:0] inst;

   int total = 0;
   int passed = 0;

   fetch_stage #(.NOP_INST(NOP), .PC_INC(32'd4)) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .start_i     (start),
      .pc_i        (pc),
      .stall_i     (stall),
      .flush_i     (flush),
      .pc_write_o  (pc_write),
      .imem_req_o  (req),
      .imem_addr_o (addr),
      .imem_ack_i  (ack),
      .imem_data_i (data),
      .ifid_valid_o(v),
      .ifid_pc_o   (ipc),
      .ifid_pc4_o  (ipc4),
      .ifid_inst_o (inst)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic        stall;
      logic        flush;
      logic        ack;
      logic [31:0] pc;
      logic [31:0] data;
      logic        pw;
      logic        req;
      logic [31:0] addr;
      logic        v;
      logic [31:0] ipc;
      logic [31:0] inst;
      logic        cpc;
   } vec_t;

   typedef struct {
      logic        v;
      logic [31:0] ipc;
      logic [31:0] ipc4;
      logic [31:0] inst;
      logic        cpc;
   } exp_t;

   vec_t tv[$];
   exp_t sb[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   function automatic vec_t mk(
      input logic st, input logic sl, input logic fl, input logic ak,
      input logic [31:0] p, input logic [31:0] d,
      input logic pw, input logic rq, input logic [31:0] ad,
      input logic ev, input logic [31:0] ep, input logic [31:0] ei,
      input logic cp);
      vec_t t;
      t.start = st; t.stall = sl; t.flush = fl; t.ack = ak;
      t.pc = p; t.data = d; t.pw = pw; t.req = rq; t.addr = ad;
      t.v = ev; t.ipc = ep; t.inst = ei; t.cpc = cp;
      return t;
   endfunction

   task automatic step(input vec_t t, input int i);
      exp_t e;
      @(negedge clk);
      start = t.start; stall = t.stall; flush = t.flush;
      ack = t.ack; pc = t.pc; data = t.data;
      #1;
      chk($sformatf("v%0d_pw", i), {31'h0, pc_write}, {31'h0, t.pw});
      chk($sformatf("v%0d_req", i), {31'h0, req}, {31'h0, t.req});
      if (t.req) chk($sformatf("v%0d_addr", i), addr, t.addr);
      e.v = t.v; e.ipc = t.ipc; e.ipc4 = t.ipc + 32'd4;
      e.inst = t.inst; e.cpc = t.cpc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_valid", i), {31'h0, v}, {31'h0, e.v});
      chk($sformatf("v%0d_inst", i), inst, e.inst);
      if (e.cpc) begin
         chk($sformatf("v%0d_pc", i), ipc, e.ipc);
         chk($sformatf("v%0d_pc4", i), ipc4, e.ipc4);
      end
   endtask

   initial begin
      // zero-wait stream 0,4,8
      tv.push_back(mk(1,0,0,0, 32'h0, 32'h0,  0,0,32'h0,  0,32'h0,NOP,0));
      tv.push_back(mk(0,0,0,1, 32'h0, 32'hA0, 1,1,32'h0,  1,32'h0,32'hA0,1));
      tv.push_back(mk(0,0,0,1, 32'h4, 32'hA1, 1,1,32'h4,  1,32'h4,32'hA1,1));
      tv.push_back(mk(0,0,0,1, 32'h8, 32'hA2, 1,1,32'h8,  1,32'h8,32'hA2,1));
      // three wait states at 0x40
      tv.push_back(mk(0,0,0,0, 32'h40,32'h0,  0,1,32'h40, 0,32'h0,NOP,0));
      tv.push_back(mk(0,0,0,0, 32'h40,32'h0,  0,1,32'h40, 0,32'h0,NOP,0));
      tv.push_back(mk(0,0,0,0, 32'h40,32'h0,  0,1,32'h40, 0,32'h0,NOP,0));
      tv.push_back(mk(0,0,0,1, 32'h40,32'hB0, 1,1,32'h40, 1,32'h40,32'hB0,1));
      // ack under stall at 0x10, held two cycles
      tv.push_back(mk(0,1,0,1, 32'h10,32'hC0, 0,1,32'h10, 1,32'h40,32'hB0,1));
      tv.push_back(mk(0,1,0,0, 32'h10,32'h0,  0,0,32'h0,  1,32'h40,32'hB0,1));
      tv.push_back(mk(0,0,0,0, 32'h10,32'h0,  1,0,32'h0,  1,32'h10,32'hC0,1));
      // flush with 0x20 outstanding, redirect to 0x80
      tv.push_back(mk(0,0,0,0, 32'h20,32'h0,  0,1,32'h20, 0,32'h0,NOP,0));
      tv.push_back(mk(0,0,1,0, 32'h20,32'h0,  1,1,32'h20, 0,32'h0,NOP,0));
      tv.push_back(mk(0,0,0,0, 32'h80,32'h0,  0,1,32'h20, 0,32'h0,NOP,0));
      tv.push_back(mk(0,0,0,1, 32'h80,32'hD0, 0,1,32'h20, 0,32'h0,NOP,0));
      tv.push_back(mk(0,0,0,1, 32'h80,32'hD1, 1,1,32'h80, 1,32'h80,32'hD1,1));
      // flush + stall + ack together: flush wins
      tv.push_back(mk(0,1,1,1, 32'h84,32'hE0, 1,1,32'h84, 0,32'h0,NOP,0));
      tv.push_back(mk(0,0,0,1, 32'h90,32'hE1, 1,1,32'h90, 1,32'h90,32'hE1,1));
      // pc4 wraps modulo 2^32
      tv.push_back(mk(0,0,0,1, 32'hFFFF_FFFC,32'hF0, 1,1,32'hFFFF_FFFC,
                      1,32'hFFFF_FFFC,32'hF0,1));
      // park in HOLD for the reset sequence
      tv.push_back(mk(0,1,0,1, 32'hA0,32'hF1, 0,1,32'hA0,
                      1,32'hFFFF_FFFC,32'hF0,1));

      #12;
      chk("rst_pw",   {31'h0, pc_write}, 32'h0);
      chk("rst_req",  {31'h0, req},      32'h0);
      chk("rst_addr", addr,              32'h0);
      chk("rst_valid",{31'h0, v},        32'h0);
      chk("rst_pc",   ipc,               32'h0);
      chk("rst_pc4",  ipc4,              32'h0);
      chk("rst_inst", inst,              NOP);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tv[i]) step(tv[i], i);

      // reset asserted while in HOLD
      @(negedge clk);
      ack = 1'b0;
      #1;
      chk("hold_req", {31'h0, req}, 32'h0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("hrst_pw",    {31'h0, pc_write}, 32'h0);
      chk("hrst_req",   {31'h0, req},      32'h0);
      chk("hrst_valid", {31'h0, v},        32'h0);
      chk("hrst_pc",    ipc,               32'h0);
      chk("hrst_pc4",   ipc4,              32'h0);
      chk("hrst_inst",  inst,              NOP);
      // late ack in IDLE with start low is ignored
      @(negedge clk);
      rst_n = 1'b1; start = 1'b0; stall = 1'b0;
      ack = 1'b1; data = 32'hBAD0; pc = 32'hB0;
      #1;
      chk("late_pw",  {31'h0, pc_write}, 32'h0);
      chk("late_req", {31'h0, req},      32'h0);
      @(posedge clk);
      #1;
      chk("late_valid", {31'h0, v}, 32'h0);
      chk("late_inst",  inst,       NOP);
      @(negedge clk);
      ack = 1'b0;
      #1;
      chk("idle_req", {31'h0, req}, 32'h0);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("restart_req",  {31'h0, req}, 32'h1);
      chk("restart_addr", addr,         32'hB0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
